// File: rtl/rv32_csr_pkg.sv
// rtl/rv32_csr_pkg.sv - shared CSR addresses, write-op encoding and helpers for rv32_csr_file
package rv32_csr_pkg;

    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_HIGH_OFS      = 12'h080;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam logic SRC_IMM = 1'b0;
    localparam logic SRC_RS1 = 1'b1;

    localparam int INH_CY       = 0;
    localparam int INH_IR       = 2;
    localparam int INH_HPM_BASE = 3;

    typedef enum logic [1:0] {
        WOP_RW   = 2'b00,
        WOP_RS   = 2'b01,
        WOP_RC   = 2'b10,
        WOP_RSVD = 2'b11
    } write_op_e;

    // Counter slot 0 is mcycle, 1 is minstret, 2+k is mhpmcounter(3+k); returns its address offset.
    function automatic logic [4:0] cnt_offset(input int idx);
        if (idx == 0) return 5'(INH_CY);
        if (idx == 1) return 5'(INH_IR);
        return 5'(idx + 1);
    endfunction

    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = (32'h1 << INH_CY) | (32'h1 << INH_IR);
        for (int n = INH_HPM_BASE; n < INH_HPM_BASE + num_hpm; n++) m = m | (32'h1 << n);
        return m;
    endfunction

    function automatic logic [31:0] apply_op(input write_op_e op, input logic [31:0] old,
                                             input logic [31:0] w);
        case (op)
            WOP_RW:  return w;
            WOP_RS:  return old | w;
            WOP_RC:  return old & ~w;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/rv32_csr_counter.sv
// rtl/rv32_csr_counter.sv - one machine counter with independently writable 32-bit halves
module rv32_csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             write_lo,
    input  logic             write_hi,
    input  logic [31:0]      write_value,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             unused_write_bits;

    // Bits of the high-half write above WIDTH are dropped.
    assign unused_write_bits = ^write_value;

    always_comb begin
        value_d = value_q;
        if (write_lo) begin
            value_d[31:0] = write_value;
        end else if (write_hi) begin
            value_d[WIDTH-1:32] = write_value[WIDTH-33:0];
        end else if (inc && !inhibit) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/rv32_csr_file.sv
// rtl/rv32_csr_file.sv - RV32 machine CSR file: counters, HPM counters, mscratch, mcountinhibit
// Define RV32_CSR_COUNTINHIBIT_EN to implement mcountinhibit storage; otherwise 0x320 reads 0.
module rv32_csr_file
    import rv32_csr_pkg::*;
#(
    parameter int  NUM_HPM       = 4,
    parameter int  COUNTER_WIDTH = 64,
    localparam int HPM_W         = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_in,
    input  logic             write_in,
    input  logic [1:0]       write_op_in,
    input  logic             src_in,
    input  logic [11:0]      csr_in,
    input  logic [31:0]      rs1_value_in,
    input  logic [31:0]      imm_value_in,
    input  logic             instr_retired_in,
    input  logic [HPM_W-1:0] hpm_event_in,
    output logic [31:0]      read_value_out,
    output logic             illegal_out
);

    localparam int NCNT = 2 + NUM_HPM;

    logic [31:0]     mscratch_q, mscratch_d;
    logic [31:0]     inhibit_rd;
    logic [NCNT-1:0] cnt_event;
    logic [63:0]     cnt_ext [NCNT];
    logic [31:0]     operand, old_value, new_value;
    logic            known, illegal, legal_write;

    assign operand = (src_in == SRC_RS1) ? rs1_value_in : imm_value_in;

    always_comb begin
        known     = 1'b0;
        old_value = 32'h0;
        case (csr_in)
            CSR_MISA: begin
                known     = 1'b1;
                old_value = MISA_VALUE;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: known = 1'b1;
            CSR_MSCRATCH: begin
                known     = 1'b1;
                old_value = mscratch_q;
            end
            CSR_MCOUNTINHIBIT: begin
                known     = 1'b1;
                old_value = inhibit_rd;
            end
            CSR_TIME: begin
                known     = 1'b1;
                old_value = cnt_ext[0][31:0];
            end
            CSR_TIMEH: begin
                known     = 1'b1;
                old_value = cnt_ext[0][63:32];
            end
            default: ;
        endcase
        // mhpmeventN exist only so software can write them; they always read 0.
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_in == CSR_MCOUNTINHIBIT + 12'(INH_HPM_BASE + i)) known = 1'b1;
        end
        for (int i = 0; i < NCNT; i++) begin
            if (csr_in == CSR_MCYCLE + {7'b0, cnt_offset(i)} ||
                csr_in == CSR_CYCLE  + {7'b0, cnt_offset(i)}) begin
                known     = 1'b1;
                old_value = cnt_ext[i][31:0];
            end
            if (csr_in == CSR_MCYCLE + CSR_HIGH_OFS + {7'b0, cnt_offset(i)} ||
                csr_in == CSR_CYCLE  + CSR_HIGH_OFS + {7'b0, cnt_offset(i)}) begin
                known     = 1'b1;
                old_value = cnt_ext[i][63:32];
            end
        end
    end

    always_comb begin
        illegal = 1'b0;
        if ((read_in || write_in) && !known) illegal = 1'b1;
        if (write_in && (csr_in[11:10] == 2'b11 || write_op_in == 2'b11)) illegal = 1'b1;
    end

    assign legal_write    = write_in && !illegal;
    assign new_value      = apply_op(write_op_e'(write_op_in), old_value, operand);
    assign read_value_out = old_value;
    assign illegal_out    = illegal;

    assign cnt_event[0] = 1'b1;
    assign cnt_event[1] = instr_retired_in;
    if (NUM_HPM > 0) begin : g_hpm_ev
        assign cnt_event[NCNT-1:2] = hpm_event_in;
    end else begin : g_no_hpm
        logic unused_hpm_event;
        assign unused_hpm_event = ^hpm_event_in;
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        localparam logic [11:0] OFS     = {7'b0, cnt_offset(g)};
        localparam int          INH_BIT = int'(cnt_offset(g));
        logic [COUNTER_WIDTH-1:0] value;

        rv32_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .inc         (cnt_event[g]),
            .inhibit     (inhibit_rd[INH_BIT]),
            .write_lo    (legal_write && csr_in == CSR_MCYCLE + OFS),
            .write_hi    (legal_write && csr_in == CSR_MCYCLE + CSR_HIGH_OFS + OFS),
            .write_value (new_value),
            .value       (value)
        );

        assign cnt_ext[g] = 64'(value);
    end

    always_comb begin
        mscratch_d = mscratch_q;
        if (legal_write && csr_in == CSR_MSCRATCH) mscratch_d = new_value;
    end

    always_ff @(posedge clk) begin
        if (reset) mscratch_q <= 32'h0;
        else       mscratch_q <= mscratch_d;
    end

`ifdef RV32_CSR_COUNTINHIBIT_EN
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);
    logic [31:0] inhibit_q, inhibit_d;

    // The counters see inhibit_q, so a new inhibit value applies from the following cycle.
    always_comb begin
        inhibit_d = inhibit_q;
        if (legal_write && csr_in == CSR_MCOUNTINHIBIT) inhibit_d = new_value & INH_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) inhibit_q <= 32'h0;
        else       inhibit_q <= inhibit_d;
    end

    assign inhibit_rd = inhibit_q;
`else
    assign inhibit_rd = 32'h0;
`endif

endmodule

// File: tb/tb_rv32_csr_file.sv
// tb/tb_rv32_csr_file.sv - scoreboard bench for rv32_csr_file with a behavioural CSR model
module tb_rv32_csr_file;

    localparam int NHPM = 4;
`ifdef RV32_CSR_COUNTINHIBIT_EN
    localparam bit INH_EN = 1'b1;
`else
    localparam bit INH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, read_in, write_in, src_in, instr_retired_in, illegal_out;
    logic [1:0]      write_op_in;
    logic [11:0]     csr_in;
    logic [31:0]     rs1_value_in, imm_value_in, read_value_out;
    logic [NHPM-1:0] hpm_event_in;
    logic            hpm0_event, illegal0;
    logic [31:0]     read_value0;

    rv32_csr_file #(.NUM_HPM(NHPM), .COUNTER_WIDTH(64)) u_dut (
        .clk(clk), .reset(reset), .read_in(read_in), .write_in(write_in),
        .write_op_in(write_op_in), .src_in(src_in), .csr_in(csr_in),
        .rs1_value_in(rs1_value_in), .imm_value_in(imm_value_in),
        .instr_retired_in(instr_retired_in), .hpm_event_in(hpm_event_in),
        .read_value_out(read_value_out), .illegal_out(illegal_out)
    );

    rv32_csr_file #(.NUM_HPM(0), .COUNTER_WIDTH(64)) u_dut0 (
        .clk(clk), .reset(reset), .read_in(read_in), .write_in(write_in),
        .write_op_in(write_op_in), .src_in(src_in), .csr_in(csr_in),
        .rs1_value_in(rs1_value_in), .imm_value_in(imm_value_in),
        .instr_retired_in(instr_retired_in), .hpm_event_in(hpm0_event),
        .read_value_out(read_value0), .illegal_out(illegal0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_val_q[$];
    logic        exp_ill_q[$];
    string       exp_name_q[$];
    logic        exp0_ill_q[$];
    logic        exp0_chk_q[$];
    logic [31:0] exp0_val_q[$];

    // Reference state, indexed by counter number N (0 cycle, 2 instret, 3.. hpm)
    logic [63:0] m_cnt [32];
    logic [31:0] m_scratch, m_inh;

    function automatic bit addr_known(input logic [11:0] a, input int nhpm);
        int n;
        n = int'(a[4:0]);
        if (a == 12'h301 || a == 12'h340 || a == 12'h320) return 1'b1;
        if (a >= 12'hF11 && a <= 12'hF14) return 1'b1;
        if (a >= 12'h323 && int'(a) < 'h323 + nhpm) return 1'b1;
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00)
            return (n == 0) || (n == 2) || (n >= 3 && n < 3 + nhpm) || (n == 1 && a[11:8] == 4'hC);
        return 1'b0;
    endfunction

    function automatic logic model_illegal(input logic rd, input logic wr, input logic [1:0] op,
                                           input logic [11:0] a, input int nhpm);
        if ((rd || wr) && !addr_known(a, nhpm)) return 1'b1;
        if (wr && (a[11:10] == 2'b11 || op == 2'b11)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [63:0] v;
        int n;
        if (!addr_known(a, NHPM)) return 32'h0;
        if (a == 12'h301) return 32'h4000_0100;
        if (a == 12'h340) return m_scratch;
        if (a == 12'h320) return m_inh;
        if (a[11:8] == 4'hB || a[11:8] == 4'hC) begin
            n = int'(a[4:0]);
            if (n == 1) n = 0;
            v = m_cnt[n];
            return a[7] ? v[63:32] : v[31:0];
        end
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rd, input logic wr, input logic [1:0] op,
                         input logic s, input logic [11:0] a, input logic [31:0] r1,
                         input logic [31:0] im, input logic ret, input logic [NHPM-1:0] ev,
                         input string nm);
        logic [31:0] old, w, nv, inh_old;
        logic        ill;
        int          wn;
        reset = rst; read_in = rd; write_in = wr; write_op_in = op; src_in = s;
        csr_in = a; rs1_value_in = r1; imm_value_in = im; instr_retired_in = ret;
        hpm_event_in = ev; hpm0_event = ev[0];
        old = model_read(a);
        ill = model_illegal(rd, wr, op, a, NHPM);
        if (rd || wr) begin
            exp_val_q.push_back(old);
            exp_ill_q.push_back(ill);
            exp_name_q.push_back(nm);
            exp0_ill_q.push_back(model_illegal(rd, wr, op, a, 0));
            exp0_chk_q.push_back(!addr_known(a, 0) || a == 12'h301);
            exp0_val_q.push_back((a == 12'h301) ? 32'h4000_0100 : 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 32; n++) m_cnt[n] = 64'h0;
            m_scratch = 32'h0;
            m_inh     = 32'h0;
        end else begin
            w       = s ? r1 : im;
            nv      = (op == 2'b00) ? w : (op == 2'b01) ? (old | w) : (old & ~w);
            wn      = -1;
            inh_old = m_inh;
            if (wr && !ill) begin
                if (a == 12'h340) m_scratch = nv;
                if (a == 12'h320 && INH_EN) m_inh = nv & (32'h5 | (((32'h1 << NHPM) - 1) << 3));
                if (a[11:8] == 4'hB && a[6:5] == 2'b00) begin
                    wn = int'(a[4:0]);
                    if (a[7]) m_cnt[wn][63:32] = nv;
                    else      m_cnt[wn][31:0]  = nv;
                end
            end
            for (int n = 0; n < 3 + NHPM; n++) begin
                if (n == 1 || n == wn || ((inh_old >> n) & 32'h1) != 0) continue;
                if (n == 0 || (n == 2 && ret) || (n >= 3 && ev[n-3])) m_cnt[n] = m_cnt[n] + 64'h1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ret = 1'b0, input logic [NHPM-1:0] ev = '0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h000, $urandom, $urandom, ret, ev, "idle");
    endtask

    task automatic rd(input logic [11:0] a, input string nm, input logic ret = 1'b0,
                      input logic [NHPM-1:0] ev = '0);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, a, $urandom, $urandom, ret, ev, nm);
    endtask

    task automatic wr(input logic [1:0] op, input logic s, input logic [11:0] a,
                      input logic [31:0] v, input string nm, input logic ret = 1'b0,
                      input logic [NHPM-1:0] ev = '0);
        drive(1'b0, 1'b1, 1'b1, op, s, a, s ? v : $urandom, s ? $urandom : v, ret, ev, nm);
    endtask

    task automatic do_reset(input logic wr_during);
        drive(1'b1, wr_during, wr_during, 2'b00, 1'b1, 12'h340, 32'hA5A5_A5A5, 32'h0, 1'b1,
              '1, "reset_write");
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0: return 12'hB00;   1: return 12'hB80;   2: return 12'hB02;   3: return 12'hB82;
            4: return 12'hB03;   5: return 12'hB04;   6: return 12'hB05;   7: return 12'hB06;
            8: return 12'hB84;   9: return 12'hB86;  10: return 12'hB07;  11: return 12'hB01;
            12: return 12'hC00; 13: return 12'hC01;  14: return 12'hC81;  15: return 12'hC02;
            16: return 12'hC84; 17: return 12'hC06;  18: return 12'h320;  19: return 12'h323;
            20: return 12'h326; 21: return 12'h327;  22: return 12'h340;  23: return 12'h301;
            24: return 12'hF11; 25: return 12'hF14;  26: return 12'h7C0;  default: return 12'(k * 97);
        endcase
    endfunction

    initial begin : monitor
        string nm;
        forever begin
            @(negedge clk);
            if (read_in || write_in) begin
                if (exp_val_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty got=access exp=none");
                end else begin
                    nm = exp_name_q.pop_front();
                    check({nm, "_value"}, read_value_out, exp_val_q.pop_front());
                    check({nm, "_illegal"}, {31'b0, illegal_out}, {31'b0, exp_ill_q.pop_front()});
                    check({nm, "_illegal_nohpm"}, {31'b0, illegal0}, {31'b0, exp0_ill_q.pop_front()});
                    if (exp0_chk_q.pop_front()) check({nm, "_value_nohpm"}, read_value0, exp0_val_q[0]);
                    void'(exp0_val_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; read_in = 1'b0; write_in = 1'b0; write_op_in = 2'b00; src_in = 1'b0;
        csr_in = 12'h0; rs1_value_in = 32'h0; imm_value_in = 32'h0; instr_retired_in = 1'b0;
        hpm_event_in = '0; hpm0_event = 1'b0;
        @(posedge clk); #1;
        do_reset(1'b0);
        rd(12'hB00, "reset_mcycle");
        rd(12'hB02, "reset_minstret");
        rd(12'hB05, "reset_hpm5");
        rd(12'h320, "reset_inhibit");
        wr(2'b00, 1'b1, 12'h340, 32'h1111_2222, "pre_reset_scratch");
        do_reset(1'b1);
        repeat (10) idle();
        rd(12'hC00, "cycle_after_10");
        rd(12'hC02, "instret_idle");
        rd(12'h340, "scratch_after_reset");

        wr(2'b00, 1'b1, 12'hB00, 32'hFFFF_FFFF, "mcycle_lo_wr");
        wr(2'b00, 1'b0, 12'hB80, 32'hFFFF_FFFF, "mcycle_hi_wr");
        rd(12'hB00, "mcycle_allones");
        rd(12'hC00, "cycle_wrapped");
        rd(12'hC80, "cycleh_wrapped");

        wr(2'b00, 1'b1, 12'h340, 32'h1234_5678, "scratch_rw");
        wr(2'b01, 1'b0, 12'h340, 32'h0000_000F, "scratch_rs");
        wr(2'b10, 1'b1, 12'h340, 32'h0000_0070, "scratch_rc");
        rd(12'h340, "scratch_final");

        wr(2'b00, 1'b0, 12'h320, 32'h5, "inhibit_set", 1'b1);
        idle(1'b1);
        for (int i = 0; i < 5; i++) rd((i % 2) ? 12'hC02 : 12'hC00, "inhibit_frozen", 1'b1);
        wr(2'b00, 1'b1, 12'h320, 32'h0, "inhibit_clear", 1'b1);
        idle(1'b1);
        rd(12'hC00, "resume_cycle", 1'b1);
        rd(12'hC02, "resume_instret", 1'b1);

        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 4'b0010);
            idle();
        end
        rd(12'hB04, "hpm4_three");
        wr(2'b00, 1'b1, 12'hB04, 32'h0000_0100, "hpm4_write_vs_pulse", 1'b0, 4'b0010);
        rd(12'hB04, "hpm4_written");

        wr(2'b00, 1'b1, 12'hC00, 32'hDEAD_BEEF, "write_ro_cycle");
        rd(12'hC00, "cycle_unchanged");
        rd(12'h7C0, "unimpl_read");
        wr(2'b11, 1'b1, 12'h340, 32'hFFFF_FFFF, "reserved_op");
        rd(12'h340, "scratch_kept");
        rd(12'hB03, "hpm3_read");
        wr(2'b00, 1'b1, 12'h323, 32'hFFFF_FFFF, "mhpmevent_write");
        rd(12'h323, "mhpmevent_read");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      pick_addr($urandom_range(0, 28)),
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                      1'($urandom_range(0, 1)), NHPM'($urandom), "random");
            end
        end

        idle();
        checks++;
        if (exp_val_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_val_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_csr_file.md
Name: rv32_csr_file

Overview:
- Parametrised successor to the RV32 read-only counter CSR block.
- Adds writable machine counters (mcycle/minstret and their high halves), NUM_HPM hardware performance counters driven by event inputs, mscratch, mcountinhibit, and illegal-access detection.
- Sits beside the execute stage: read is combinational, and the write commits at the next rising clk edge.

Parameters:
- NUM_HPM, 4, number of mhpmcounterN/N-h pairs implemented (0..29), N = 3..3+NUM_HPM-1.
- COUNTER_WIDTH, 64, width of every counter (33..64). Bits above the width read 0 and are discarded on write.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- read_in  input  1  CSR instruction reads csr_in
- write_in  input  1  CSR instruction writes csr_in
- write_op_in  input  2  00 RW, 01 RS, 10 RC; 11 is reserved and flags illegal when write_in=1
- src_in  input  1  0 selects imm_value_in, 1 selects rs1_value_in
- csr_in  input  12  CSR address
- rs1_value_in  input  32  register operand
- imm_value_in  input  32  zero-extended uimm operand
- instr_retired_in  input  1  one instruction retired this cycle (from writeback)
- hpm_event_in  input  max(NUM_HPM,1)  per-counter increment strobe
- read_value_out  output  32  current CSR value (combinational)
- illegal_out  output  1  access is illegal (combinational)

Behaviour:
- Reset:
  - All counters, mscratch and mcountinhibit are 0 at the edge where reset=1.
  - Outputs are combinational, so after reset read_value_out=0 for counter addresses.
  - reset dominates writes and increments in the same cycle.
- Address map, read-only:
  - misa 0x301 = 0x40000100.
  - mvendorid, marchid, mimpid, mhartid (0xF11-0xF14) = 0.
- Address map, shadows (read-only):
  - cycle/time 0xC00/0xC01, instret 0xC02, hpmcounterN 0xC00+N.
  - High halves at +0x80.
- Address map, writable:
  - mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N, high halves +0x80.
  - mcountinhibit 0x320: bit0 CY, bit2 IR, bitN HPM; other bits read 0.
  - mscratch 0x340.
  - mhpmeventN 0x320+N reads 0; writes are accepted and ignored.
- Illegal access (illegal_out=1, no state change):
  - (read_in|write_in) with an unimplemented address.
  - write_in with csr_in[11:10]==2'b11.
  - write_in with write_op_in=11.
  - Unimplemented addresses read 0 (not x).
- New value: src-selected operand w.
  - RW gives w; RS gives old|w; RC gives old&~w.
  - old is the value presented on read_value_out this cycle.
- Counter update each cycle, per counter:
  - If a legal write targets its low or high half, that half takes the new value, the other half holds, and the increment is suppressed that cycle.
  - Else if its inhibit bit is 0 and its event is active, it increments by 1.
  - Events: mcycle always; minstret uses instr_retired_in; HPM N uses hpm_event_in[N-3].
- Wrap: all-ones + 1 gives 0, with no trap and no sticky flag.
- Read timing: a counter read returns the pre-increment value. A write is visible to a read in the following cycle.
- Simultaneous events: writing mcountinhibit takes effect from the next cycle. Counting in the write cycle uses the old inhibit value.
- When NUM_HPM=0, hpm_event_in is ignored and all hpm addresses are illegal.

Optional Feature:
- Macro: RV32_CSR_COUNTINHIBIT_EN.
- Defined: mcountinhibit is implemented as above.
- Undefined:
  - 0x320 still decodes legally but reads 0.
  - Writes to 0x320 are ignored.
  - All counters count unconditionally.

Decomposition:
- Package rv32_csr_pkg holds:
  - CSR address constants.
  - A write-op enum (RW/RS/RC).
  - Source-select constants.
  - The misa value.
  - Inhibit bit indices.
- Sub-module rv32_csr_counter (parameter WIDTH), instantiated 2+NUM_HPM times. Its ports:
  - clk, reset, inc, inhibit
  - write_lo, write_hi, write_value[31:0]
  - value[WIDTH-1:0]

Test Plan:
- Reset, release, idle 10 cycles: read 0xC00 returns 10; read 0xC02 with instr_retired_in=0 returns 0.
- RW mcycle 0xB00 with 0xFFFFFFFF and mcycleh 0xB80 with 0xFFFFFFFF: in the cycle after the second write, mcycle=0xFFFFFFFF_FFFFFFFF; one cycle later, reads of 0xC00 and 0xC80 return 0.
- mscratch: RW 0x12345678, then RS 0x0000000F gives 0x1234567F, then RC 0x00000070 gives 0x1234560F, with src_in toggling between rs1 and imm.
- Inhibit (macro defined): RW 0x320 with 0x5. After one settling cycle, mcycle and minstret are frozen for 5 cycles with instr_retired_in=1. Clear to 0 and both resume counting. With the macro undefined, both count throughout.
- HPM: pulse hpm_event_in[1] 3 times; read 0xB04 returns 3. Write 0xB04 in the same cycle as a pulse: the written value wins and the pulse is dropped.
- Illegal access:
  - Write to 0xC00 gives illegal_out=1 and the counter is unchanged.
  - Read of 0x7C0 gives illegal_out=1 and reads 0.
  - write_op_in=11 on mscratch gives illegal_out=1 and mscratch unchanged.
  - With NUM_HPM=0, a read of 0xB03 is illegal.
